// File: rtl/aer_frame_spike_encoder.sv
// rtl/aer_frame_spike_encoder.sv - frame buffer plus deterministic rate coder emitting 4-phase AER events
// Loads one raster frame, then runs TIME_STEP accumulate-and-fire passes with time-step/sample markers.
module aer_frame_spike_encoder #(
  parameter int FM_W      = 16,
  parameter int FM_H      = 16,
  parameter int FM_C      = 1,
  parameter int TIME_STEP = 8,
  parameter int PIX_WIDTH = 8,
  localparam int N     = FM_C * FM_W * FM_H,
  localparam int IDX_W = $clog2(N),
  localparam int AER_W = IDX_W + 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PIX_VALID,
  input  logic [PIX_WIDTH-1:0] PIX_DATA,
  output logic                 PIX_READY,
  output logic                 AEROUT_REQ,
  output logic [AER_W-1:0]     AEROUT_ADDR,
  input  logic                 AEROUT_ACK,
  output logic                 BUSY,
  output logic                 SAMPLE_DONE
);

  localparam int TW = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
  localparam logic [IDX_W-1:0]     LAST_IDX    = IDX_W'(N - 1);
  localparam logic [TW-1:0]        LAST_T      = TW'(TIME_STEP - 1);
  localparam logic [PIX_WIDTH-1:0] ACC_INIT    = {1'b1, {(PIX_WIDTH-1){1'b0}}};
  localparam logic [1:0]           TYPE_SPIKE  = 2'b00;
  localparam logic [1:0]           TYPE_TSTEP  = 2'b01;
  localparam logic [1:0]           TYPE_SAMPLE = 2'b10;

  typedef enum logic [2:0] {LOAD, SCAN, REQ, REL, MARK_T, MARK_S, DONE} state_t;

  state_t               state;
  logic [IDX_W-1:0]     cnt;
  logic [IDX_W-1:0]     idx;
  logic [TW-1:0]        t;
  logic [PIX_WIDTH-1:0] pix_mem [N];
  logic [PIX_WIDTH-1:0] acc_mem [N];
  logic [PIX_WIDTH:0]   sum;
  logic                 accept;

  assign accept    = PIX_VALID && (state == LOAD);
  assign sum       = {1'b0, acc_mem[idx]} + {1'b0, pix_mem[idx]};
  assign PIX_READY = (state == LOAD);
  assign BUSY      = (state != LOAD);

  // Dropping the carry bit is the same as subtracting 2^PIX_WIDTH after a spike.
  always_ff @(posedge clk) begin
    if (accept) begin
      pix_mem[cnt] <= PIX_DATA;
      acc_mem[cnt] <= ACC_INIT;
    end else if (state == SCAN) begin
      acc_mem[idx] <= sum[PIX_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= LOAD;
      cnt         <= '0;
      idx         <= '0;
      t           <= '0;
      AEROUT_REQ  <= 1'b0;
      AEROUT_ADDR <= '0;
      SAMPLE_DONE <= 1'b0;
    end else begin
      SAMPLE_DONE <= 1'b0;
      case (state)
        LOAD: begin
          if (PIX_VALID) begin
            if (cnt == LAST_IDX) begin
              cnt   <= '0;
              idx   <= '0;
              t     <= '0;
              state <= SCAN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SCAN: begin
          if (sum[PIX_WIDTH]) begin
            AEROUT_ADDR <= {TYPE_SPIKE, idx};
            AEROUT_REQ  <= ~AEROUT_ACK;
            state       <= REQ;
          end else if (idx == LAST_IDX) begin
            state <= MARK_T;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        // A request is only raised once ACK has been observed low.
        REQ: begin
          if (AEROUT_REQ && AEROUT_ACK) begin
            AEROUT_REQ <= 1'b0;
            state      <= REL;
          end else if (!AEROUT_REQ && !AEROUT_ACK) begin
            AEROUT_REQ <= 1'b1;
          end
        end
        REL: begin
          if (!AEROUT_ACK) begin
            case (AEROUT_ADDR[AER_W-1 -: 2])
              TYPE_SPIKE: begin
                if (idx == LAST_IDX) begin
                  state <= MARK_T;
                end else begin
                  idx   <= idx + 1'b1;
                  state <= SCAN;
                end
              end
              TYPE_TSTEP: begin
                if (t == LAST_T) begin
                  state <= MARK_S;
                end else begin
                  t     <= t + 1'b1;
                  idx   <= '0;
                  state <= SCAN;
                end
              end
              default: begin
                SAMPLE_DONE <= 1'b1;
                state       <= DONE;
              end
            endcase
          end
        end
        MARK_T: begin
          AEROUT_ADDR <= {TYPE_TSTEP, {IDX_W{1'b0}}};
          AEROUT_REQ  <= ~AEROUT_ACK;
          state       <= REQ;
        end
        MARK_S: begin
          AEROUT_ADDR <= {TYPE_SAMPLE, {IDX_W{1'b0}}};
          AEROUT_REQ  <= ~AEROUT_ACK;
          state       <= REQ;
        end
        DONE: begin
          cnt   <= '0;
          state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_aer_frame_spike_encoder.sv
// tb/tb_aer_frame_spike_encoder.sv - randomized self-checking bench for aer_frame_spike_encoder
// Arithmetic reference model of the rate coder; a negedge process acts as the AER receiver.
module tb_aer_frame_spike_encoder;

  localparam int FM_W = 16;
  localparam int FM_H = 16;
  localparam int FM_C = 1;
  localparam int TS   = 8;
  localparam int PW   = 8;
  localparam int N     = FM_C * FM_W * FM_H;
  localparam int IDX_W = $clog2(N);
  localparam int AER_W = IDX_W + 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pix_valid = 1'b0;
  logic [PW-1:0]    pix_data = '0;
  logic             pix_ready;
  logic             req;
  logic [AER_W-1:0] addr;
  logic             ack = 1'b0;
  logic             busy;
  logic             sample_done;

  aer_frame_spike_encoder #(
    .FM_W(FM_W), .FM_H(FM_H), .FM_C(FM_C), .TIME_STEP(TS), .PIX_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst),
    .PIX_VALID(pix_valid), .PIX_DATA(pix_data), .PIX_READY(pix_ready),
    .AEROUT_REQ(req), .AEROUT_ADDR(addr), .AEROUT_ACK(ack),
    .BUSY(busy), .SAMPLE_DONE(sample_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [PW-1:0]    frame [N];
  logic [AER_W-1:0] events [$];
  logic [AER_W-1:0] gold [$];
  int done_pulses = 0;
  int viol_rise = 0;
  int viol_addr = 0;
  int max_delay = 0;

  // Receiver: records each request, flags protocol violations, answers after a random delay.
  initial begin : receiver
    logic             prev_req;
    logic [AER_W-1:0] prev_addr;
    int               dly;
    prev_req  = 1'b0;
    prev_addr = '0;
    dly       = 0;
    forever begin
      @(negedge clk);
      if (req && !prev_req) begin
        if (ack) viol_rise++;
        events.push_back(addr);
      end
      if (req && prev_req && addr !== prev_addr) viol_addr++;
      if (sample_done) done_pulses++;
      prev_req  = req;
      prev_addr = addr;
      if (req !== ack) begin
        if (dly == 0) begin
          ack = req;
          dly = int'($urandom_range(max_delay, 0));
        end else begin
          dly--;
        end
      end
    end
  end

  task automatic build_gold();
    int acc [N];
    gold.delete();
    for (int i = 0; i < N; i++) acc[i] = 2 ** (PW - 1);
    for (int s = 0; s < TS; s++) begin
      for (int i = 0; i < N; i++) begin
        acc[i] += int'(frame[i]);
        if (acc[i] >= 2 ** PW) begin
          acc[i] -= 2 ** PW;
          gold.push_back(AER_W'(i));
        end
      end
      gold.push_back({2'b01, {IDX_W{1'b0}}});
    end
    gold.push_back({2'b10, {IDX_W{1'b0}}});
  endtask

  task automatic load_frame(input string name);
    int drops;
    drops = 0;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      pix_valid = 1'b1;
      pix_data  = frame[i];
      if (pix_ready !== 1'b1) drops++;
      @(posedge clk); #1;
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL %s ready_during_load: %0d cycles not ready, required 0", name, drops);
    end
    checks++;
    if ({pix_ready, busy} !== 2'b01) begin
      errors++;
      $display("FAIL %s ready_after_load: ready=%b busy=%b, required ready=0 busy=1", name, pix_ready, busy);
    end
    repeat (3) begin
      pix_data = PW'($urandom);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input int pbase, input int budget, input string name);
    int n;
    n = 0;
    while (done_pulses == pbase && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_pulses == pbase) begin
      errors++;
      $display("FAIL %s sample_done_timeout: no pulse within %0d cycles", name, budget);
    end
  endtask

  task automatic compare_events(input int ebase, input string name);
    int n;
    int first;
    int lim;
    logic [AER_W-1:0] got;
    logic [AER_W-1:0] exp;
    n     = events.size() - ebase;
    lim   = (n < gold.size()) ? n : gold.size();
    first = -1;
    for (int i = 0; i < lim; i++)
      if (first < 0 && events[ebase + i] !== gold[i]) first = i;
    if (first < 0 && n != gold.size()) first = lim;
    checks++;
    if (first >= 0) begin
      got = (first < n) ? events[ebase + first] : 'x;
      exp = (first < gold.size()) ? gold[first] : 'x;
      errors++;
      $display("FAIL %s event_list: at %0d got %h (of %0d) required %h (of %0d)",
               name, first, got, n, exp, gold.size());
    end
  endtask

  task automatic run_sample(input string name, input int delay, input int budget, output int ebase);
    int pbase;
    max_delay = delay;
    build_gold();
    ebase = events.size();
    pbase = done_pulses;
    load_frame(name);
    wait_done(pbase, budget, name);
    repeat (3) @(negedge clk);
    checks++;
    if (done_pulses - pbase != 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d required 1", name, done_pulses - pbase);
    end
    compare_events(ebase, name);
  endtask

  task automatic count_types(input int ebase, output int sp, output int mt, output int ms);
    sp = 0; mt = 0; ms = 0;
    for (int i = ebase; i < events.size(); i++) begin
      case (events[i][AER_W-1 -: 2])
        2'b00:   sp++;
        2'b01:   mt++;
        default: ms++;
      endcase
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req, addr, busy, sample_done, pix_ready} !== {1'b0, {AER_W{1'b0}}, 3'b001}) begin
      errors++;
      $display("FAIL reset_values: req=%b addr=%h busy=%b done=%b ready=%b, required 0 0 0 0 1",
               req, addr, busy, sample_done, pix_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req, busy, pix_ready} !== 3'b001) begin
      errors++;
      $display("FAIL post_reset_idle: req=%b busy=%b ready=%b, required 0 0 1", req, busy, pix_ready);
    end
  endtask

  task automatic test_reset_mid_load();
    int eb;
    for (int i = 0; i < 10; i++) begin
      pix_valid = 1'b1;
      pix_data  = PW'($urandom);
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < N; i++) frame[i] = PW'($urandom);
    run_sample("reset_mid_load", 0, 20000, eb);
  endtask

  task automatic test_zero_frame();
    int eb, sp, mt, ms;
    for (int i = 0; i < N; i++) frame[i] = '0;
    run_sample("zero_frame", 0, 20000, eb);
    count_types(eb, sp, mt, ms);
    checks++;
    if (sp != 0) begin errors++; $display("FAIL zero_frame spikes: got %0d required 0", sp); end
    checks++;
    if (mt != TS) begin errors++; $display("FAIL zero_frame tstep_markers: got %0d required %0d", mt, TS); end
    checks++;
    if (ms != 1) begin errors++; $display("FAIL zero_frame sample_markers: got %0d required 1", ms); end
  endtask

  task automatic test_single_pixel();
    int eb, sp, marks, at_mark;
    logic [AER_W-1:0] sp_addr;
    for (int i = 0; i < N; i++) frame[i] = '0;
    frame[5] = 8'd32;
    run_sample("single_pixel", 0, 20000, eb);
    sp = 0; marks = 0; at_mark = -1; sp_addr = '0;
    for (int i = eb; i < events.size(); i++) begin
      if (events[i][AER_W-1 -: 2] == 2'b00) begin
        sp++;
        sp_addr = events[i];
        at_mark = marks;
      end else if (events[i][AER_W-1 -: 2] == 2'b01) begin
        marks++;
      end
    end
    checks++;
    if (sp != 1) begin errors++; $display("FAIL single_pixel spike_count: got %0d required 1", sp); end
    checks++;
    if (sp_addr !== AER_W'(5)) begin
      errors++; $display("FAIL single_pixel spike_addr: got %h required %h", sp_addr, AER_W'(5));
    end
    checks++;
    if (at_mark != 3) begin
      errors++; $display("FAIL single_pixel spike_pass: got %0d required 3", at_mark);
    end
  endtask

  task automatic check_pixel_counts(input int ebase, input string name);
    int cntp [N];
    int bad;
    int exp;
    for (int i = 0; i < N; i++) cntp[i] = 0;
    for (int i = ebase; i < events.size(); i++)
      if (events[i][AER_W-1 -: 2] == 2'b00) cntp[int'(events[i][IDX_W-1:0])]++;
    bad = -1;
    for (int i = 0; i < N; i++) begin
      exp = (2 ** (PW - 1) + TS * int'(frame[i])) / (2 ** PW);
      if (bad < 0 && cntp[i] != exp) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s pixel_spikes: idx %0d p=%0d got %0d required %0d", name, bad, frame[bad],
               cntp[bad], (2 ** (PW - 1) + TS * int'(frame[bad])) / (2 ** PW));
    end
  endtask

  task automatic test_all_max();
    int eb, last, bad;
    for (int i = 0; i < N; i++) frame[i] = 8'd255;
    run_sample("all_max", 0, 30000, eb);
    check_pixel_counts(eb, "all_max");
    last = -1; bad = 0;
    for (int i = eb; i < events.size(); i++) begin
      if (events[i][AER_W-1 -: 2] == 2'b00) begin
        if (int'(events[i][IDX_W-1:0]) <= last) bad++;
        last = int'(events[i][IDX_W-1:0]);
      end else begin
        last = -1;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL all_max ascending: %0d out-of-order spikes, required 0", bad); end
  endtask

  task automatic test_random_ack();
    int eb, vr, va;
    vr = viol_rise; va = viol_addr;
    for (int i = 0; i < N; i++) frame[i] = PW'($urandom);
    run_sample("random_ack", 20, 60000, eb);
    max_delay = 0;
    check_pixel_counts(eb, "random_ack");
    checks++;
    if (viol_rise != vr) begin
      errors++; $display("FAIL random_ack req_rise_with_ack: got %0d required 0", viol_rise - vr);
    end
    checks++;
    if (viol_addr != va) begin
      errors++; $display("FAIL random_ack addr_unstable: got %0d required 0", viol_addr - va);
    end
  endtask

  task automatic test_reset_mid_sample();
    int eb, marks, n;
    logic hit;
    for (int i = 0; i < N; i++) frame[i] = PW'($urandom_range(255, 64));
    max_delay = 2;
    eb = events.size();
    load_frame("reset_mid_sample");
    n = 0; hit = 1'b0;
    while (!hit && n < 20000) begin
      @(negedge clk);
      n++;
      marks = 0;
      for (int i = eb; i < events.size(); i++)
        if (events[i][AER_W-1 -: 2] == 2'b01) marks++;
      hit = (marks == 2) && req && (addr[AER_W-1 -: 2] == 2'b00);
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL reset_mid_sample reach_pass2_spike: not reached in %0d cycles", n); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({req, busy, pix_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_sample async: req=%b busy=%b ready=%b, required 0 0 1", req, busy, pix_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    n = 0;
    while (ack && n < 100) begin @(negedge clk); n++; end
    run_sample("after_reset_sample", 0, 30000, eb);
  endtask

  initial begin
    test_reset();
    test_reset_mid_load();
    test_zero_frame();
    test_single_pixel();
    test_all_max();
    test_random_ack();
    test_reset_mid_sample();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
